// File: rtl/icap_reboot_ctrl_if.sv
// Classic Wishbone link (single master, single slave) used on both sides of the ICAP arbiter.
interface icap_reboot_ctrl_if;
  localparam int unsigned DW = 32;

  logic          cyc;
  logic          stb;
  logic          we;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          ack;

  modport master (output cyc, stb, we, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, dat_w, output dat_r, ack);
endinterface

// File: rtl/icap_reboot_ctrl.sv
// ICAP port arbiter: CPU pass-through, plus a sequencer that streams the
// Spartan-3A IPROG multiboot command sequence to reboot from boot_addr.
module icap_reboot_ctrl #(
  parameter logic [7:0]  SPI_OPCODE  = 8'h0B,
  parameter bit          BIT_SWAP    = 1'b1,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned POST_WAIT   = 65535
) (
  input  logic                clk,
  input  logic                reset,
  icap_reboot_ctrl_if.slave   s,
  icap_reboot_ctrl_if.master  m,
  input  logic                reboot_req,
  input  logic [23:0]         boot_addr,
  output logic                busy,
  output logic                fail
);

  localparam int unsigned DW       = 32;
  localparam int unsigned AW       = 24;
  localparam int unsigned IW       = 5;
  localparam int unsigned LAST_IDX = 27;
  localparam int unsigned CNT_MAX  = (ACK_TIMEOUT > POST_WAIT) ? ACK_TIMEOUT : POST_WAIT;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_XFER, S_POST, S_FAIL} state_t;

  state_t          state;
  logic [AW-1:0]   addr_q;
  logic [IW-1:0]   byte_idx;
  logic [CW-1:0]   cnt;
  logic            m_cyc_q, m_stb_q, m_we_q;
  logic [DW-1:0]   m_dat_q;
  logic            s_ack_q;
  logic [DW-1:0]   s_dat_q;
  logic            busy_q, fail_q;

  logic [15:0]     word;
  logic [7:0]      raw_byte;
  logic [7:0]      swp_byte;
  logic [7:0]      seq_byte;

  assign m.cyc   = m_cyc_q;
  assign m.stb   = m_stb_q;
  assign m.we    = m_we_q;
  assign m.dat_w = m_dat_q;
  assign s.ack   = s_ack_q;
  assign s.dat_r = s_dat_q;
  assign busy    = busy_q;
  assign fail    = fail_q;

  // IPROG command byte selected by byte_idx (MSB byte of each word first).
  always_comb begin
    word     = 16'hFFFF;
    raw_byte = 8'h00;
    swp_byte = 8'h00;
    seq_byte = 8'h00;
    case (byte_idx[4:1])
      4'd0:    word = 16'hFFFF;
      4'd1:    word = 16'hAA99;
      4'd2:    word = 16'h3261;
      4'd3:    word = addr_q[15:0];
      4'd4:    word = 16'h3281;
      4'd5:    word = {SPI_OPCODE, addr_q[23:16]};
      4'd6:    word = 16'h32A1;
      4'd7:    word = 16'h0000;
      4'd8:    word = 16'h32C1;
      4'd9:    word = {SPI_OPCODE, 8'h00};
      4'd10:   word = 16'h30A1;
      4'd11:   word = 16'h000E;
      4'd12:   word = 16'h2000;
      4'd13:   word = 16'h2000;
      default: word = 16'hFFFF;
    endcase
    raw_byte = byte_idx[0] ? word[7:0] : word[15:8];
    for (int i = 0; i < 8; i++) swp_byte[i] = raw_byte[7-i];
    seq_byte = BIT_SWAP ? swp_byte : raw_byte;
  end

  // Ownership FSM with registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      byte_idx <= '0;
      cnt      <= '0;
      m_cyc_q  <= 1'b0;
      m_stb_q  <= 1'b0;
      m_we_q   <= 1'b0;
      m_dat_q  <= '0;
      s_ack_q  <= 1'b0;
      s_dat_q  <= '0;
      busy_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      s_ack_q <= 1'b0;
      case (state)
        S_IDLE, S_FAIL: begin
          s_ack_q <= m.ack & m_stb_q;
          if (m.ack) s_dat_q <= m.dat_r;
          if (reboot_req) begin
            addr_q   <= boot_addr;
            fail_q   <= 1'b0;
            byte_idx <= '0;
            cnt      <= '0;
            busy_q   <= 1'b1;
            if (m_stb_q && !m.ack) begin
              // CPU transfer already on the bus: let it finish first.
              state <= S_DRAIN;
            end else begin
              state   <= S_XFER;
              m_cyc_q <= 1'b1;
              m_stb_q <= 1'b0;
              m_we_q  <= 1'b1;
              m_dat_q <= '0;
            end
          end else begin
            // Stb drops after an ack so a CPU still holding stb is not replayed.
            m_cyc_q <= s.cyc;
            m_stb_q <= s.cyc & s.stb & ~m.ack & ~s_ack_q;
            m_we_q  <= s.we;
            m_dat_q <= s.dat_w;
          end
        end

        S_DRAIN: begin
          if (m.ack) begin
            s_ack_q <= 1'b1;
            s_dat_q <= m.dat_r;
            m_cyc_q <= 1'b1;
            m_stb_q <= 1'b0;
            m_we_q  <= 1'b1;
            cnt     <= '0;
            state   <= S_XFER;
          end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
            state   <= S_FAIL;
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            m_we_q  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_XFER: begin
          if (!m_stb_q) begin
            m_stb_q <= 1'b1;
            m_dat_q <= {24'd0, seq_byte};
            cnt     <= '0;
          end else if (m.ack) begin
            m_stb_q <= 1'b0;
            if (byte_idx == IW'(LAST_IDX)) begin
              state   <= S_POST;
              m_cyc_q <= 1'b0;
              m_we_q  <= 1'b0;
              cnt     <= '0;
            end else begin
              byte_idx <= byte_idx + IW'(1);
            end
          end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
            state   <= S_FAIL;
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            m_we_q  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_POST: begin
          // FPGA normally reconfigures here; surviving POST_WAIT cycles means it did not.
          if (cnt == CW'(POST_WAIT - 1)) begin
            state  <= S_FAIL;
            fail_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icap_reboot_ctrl.sv
// Directed bench for icap_reboot_ctrl with a write scoreboard on the ICAP side.
module tb_icap_reboot_ctrl;

  localparam int unsigned ACK_TO = 255;
  localparam int unsigned PW     = 2000;
  localparam logic [31:0] RD_VAL = 32'hCAFE_F00D;

  logic        clk;
  logic        reset;
  logic        reboot_req;
  logic [23:0] boot_addr;
  logic        busy;
  logic        fail;
  logic        hold;
  logic        slv_ack;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;

  logic [32:0] exp_q[$];

  icap_reboot_ctrl_if cpu ();
  icap_reboot_ctrl_if icap ();

  icap_reboot_ctrl #(
    .SPI_OPCODE (8'h0B),
    .BIT_SWAP   (1'b1),
    .ACK_TIMEOUT(ACK_TO),
    .POST_WAIT  (PW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s         (cpu.slave),
    .m         (icap.master),
    .reboot_req(reboot_req),
    .boot_addr (boot_addr),
    .busy      (busy),
    .fail      (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ICAP slave model: ack in the second cycle of stb unless held off.
  always @(posedge clk) begin
    if (reset) slv_ack <= 1'b0;
    else       slv_ack <= icap.stb & ~slv_ack & ~hold;
  end
  assign icap.ack   = slv_ack;
  assign icap.dat_r = RD_VAL;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Expected IPROG stream, bit-swapped per byte.
  task automatic push_seq(input logic [23:0] a);
    logic [7:0] t[28];
    t = '{8'hFF, 8'hFF, 8'hAA, 8'h99, 8'h32, 8'h61, a[15:8], a[7:0],
          8'h32, 8'h81, 8'h0B, a[23:16], 8'h32, 8'hA1, 8'h00, 8'h00,
          8'h32, 8'hC1, 8'h0B, 8'h00, 8'h30, 8'hA1, 8'h00, 8'h0E,
          8'h20, 8'h00, 8'h20, 8'h00};
    for (int i = 0; i < 28; i++) exp_q.push_back({1'b1, 24'd0, rev8(t[i])});
  endtask

  // Scoreboard: every completed ICAP transfer must match the queue head.
  always @(negedge clk) begin
    if (!reset && icap.cyc && icap.stb && icap.ack) begin
      n_wr++;
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL icap_xfer: unexpected transfer %0h, expected none", icap.dat_w);
      end
      if (exp_q.size() != 0) check("icap_xfer", 64'({icap.we, icap.dat_w}), 64'(exp_q.pop_front()));
    end
  end

  task automatic cpu_xfer(input logic we, input logic [31:0] d,
                          output logic [31:0] rd, output int acks);
    acks = 0;
    rd   = '0;
    cpu.cyc = 1'b1; cpu.stb = 1'b1; cpu.we = we; cpu.dat_w = d;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cpu.ack) begin
        acks++;
        rd = cpu.dat_r;
        cpu.cyc = 1'b0; cpu.stb = 1'b0; cpu.we = 1'b0; cpu.dat_w = '0;
      end
    end
    cpu.cyc = 1'b0; cpu.stb = 1'b0; cpu.we = 1'b0; cpu.dat_w = '0;
  endtask

  initial begin
    logic [31:0] rd;
    int acks, xfer_c, post_c, stb_c, base, guard;

    reset = 1'b1; reboot_req = 1'b0; boot_addr = '0; hold = 1'b0;
    cpu.cyc = 1'b0; cpu.stb = 1'b0; cpu.we = 1'b0; cpu.dat_w = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_m_cyc", 64'(icap.cyc), 64'd0);
    check("rst_m_stb", 64'(icap.stb), 64'd0);
    check("rst_m_we",  64'(icap.we), 64'd0);
    check("rst_m_dat", 64'(icap.dat_w), 64'd0);
    check("rst_s_ack", 64'(cpu.ack), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_fail",  64'(fail), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // CPU write and read pass-through
    exp_q.push_back({1'b1, 32'h0000_005A});
    cpu_xfer(1'b1, 32'h0000_005A, rd, acks);
    check("cpu_wr_acks", 64'(acks), 64'd1);
    exp_q.push_back({1'b0, 32'h0000_0000});
    cpu_xfer(1'b0, 32'h0, rd, acks);
    check("cpu_rd_acks", 64'(acks), 64'd1);
    check("cpu_rd_data", 64'(rd), 64'(RD_VAL));

    // Full IPROG sequence; a second request mid-sequence must be ignored
    push_seq(24'h0A_BCDE);
    reboot_req = 1'b1; boot_addr = 24'h0A_BCDE;
    @(negedge clk);
    reboot_req = 1'b0;
    check("seq_busy_start", 64'(busy), 64'd1);
    xfer_c = 0; post_c = 0; guard = 0;
    while (busy && guard < 84 + PW + 200) begin
      if (icap.cyc) xfer_c++; else post_c++;
      guard++;
      if (guard == 20) begin reboot_req = 1'b1; boot_addr = 24'h12_3456; end
      else reboot_req = 1'b0;
      @(negedge clk);
    end
    reboot_req = 1'b0;
    check("seq_busy_end", 64'(busy), 64'd0);
    check("seq_xfer_cycles", 64'(xfer_c), 64'd84);
    check("seq_post_cycles", 64'(post_c), 64'(PW));
    check("post_fail", 64'(fail), 64'd1);
    check("seq_all_sent", 64'(exp_q.size()), 64'd0);

    // Reboot during a CPU transfer, then ack withheld on byte 5
    base = n_wr;
    exp_q.push_back({1'b1, 32'h0000_0033});
    push_seq(24'h01_0203);
    cpu.cyc = 1'b1; cpu.stb = 1'b1; cpu.we = 1'b1; cpu.dat_w = 32'h33;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!icap.stb && guard < 20);
    check("drain_cpu_stb_seen", 64'(icap.stb), 64'd1);
    reboot_req = 1'b1; boot_addr = 24'h01_0203;
    @(negedge clk);
    reboot_req = 1'b0;
    check("drain_fail_cleared", 64'(fail), 64'd0);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (cpu.ack) begin
        acks++;
        cpu.cyc = 1'b0; cpu.stb = 1'b0; cpu.we = 1'b0; cpu.dat_w = '0;
      end
      @(negedge clk);
    end
    check("drain_cpu_acks", 64'(acks), 64'd1);
    check("drain_busy", 64'(busy), 64'd1);
    guard = 0;
    while (n_wr < base + 6 && guard < 100) begin @(negedge clk); guard++; end
    hold = 1'b1;
    stb_c = 0; guard = 0;
    while (busy && guard < 2 * ACK_TO) begin
      @(negedge clk);
      if (icap.stb) stb_c++;
      guard++;
    end
    check("to_stb_cycles", 64'(stb_c), 64'(ACK_TO));
    check("to_fail", 64'(fail), 64'd1);
    check("to_busy", 64'(busy), 64'd0);
    check("to_m_cyc", 64'(icap.cyc), 64'd0);
    check("to_left", 64'(exp_q.size()), 64'd23);
    exp_q.delete();
    hold = 1'b0;
    @(negedge clk);
    exp_q.push_back({1'b1, 32'h0000_0077});
    cpu_xfer(1'b1, 32'h0000_0077, rd, acks);
    check("fail_cpu_acks", 64'(acks), 64'd1);
    check("fail_sticky", 64'(fail), 64'd1);

    // Reboot with simultaneous CPU stb, then reset at byte 10
    base = n_wr;
    push_seq(24'hFE_DCBA);
    reboot_req = 1'b1; boot_addr = 24'hFE_DCBA;
    cpu.cyc = 1'b1; cpu.stb = 1'b1; cpu.we = 1'b1; cpu.dat_w = 32'h99;
    @(negedge clk);
    reboot_req = 1'b0;
    check("rs_fail_cleared", 64'(fail), 64'd0);
    acks = 0; guard = 0;
    while (n_wr < base + 10 && guard < 100) begin
      if (cpu.ack) acks++;
      @(negedge clk); guard++;
    end
    repeat (2) begin if (cpu.ack) acks++; @(negedge clk); end
    check("rs_cpu_stalled", 64'(acks), 64'd0);
    check("rs_m_stb_mid", 64'(icap.stb), 64'd1);
    reset = 1'b1;
    cpu.cyc = 1'b0; cpu.stb = 1'b0; cpu.we = 1'b0; cpu.dat_w = '0;
    @(negedge clk);
    check("rs_m_stb", 64'(icap.stb), 64'd0);
    check("rs_m_cyc", 64'(icap.cyc), 64'd0);
    check("rs_m_we",  64'(icap.we), 64'd0);
    check("rs_m_dat", 64'(icap.dat_w), 64'd0);
    check("rs_busy",  64'(busy), 64'd0);
    check("rs_fail",  64'(fail), 64'd0);
    check("rs_left",  64'(exp_q.size()), 64'd18);
    exp_q.delete();
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
